// File: rtl/mrd_dft_pkg.sv
// Shared types and helpers for the mixed-radix DFT engines: wide complex type,
// transform direction, and the round-half-up / saturate primitive.
package mrd_dft_pkg;

    localparam int W_MAX     = 64;
    localparam int SHIFT_MAX = 2;

    typedef logic signed [W_MAX-1:0] wide_t;
    typedef struct packed {
        wide_t re;
        wide_t im;
    } cplx_t;
    typedef enum logic {FWD = 1'b0, INV = 1'b1} mode_t;
    typedef struct packed {
        logic  ovf;
        wide_t v;
    } sat_res_t;

    function automatic cplx_t c_add(input cplx_t a, input cplx_t b);
        cplx_t r;
        r.re = a.re + b.re;
        r.im = a.im + b.im;
        return r;
    endfunction

    function automatic cplx_t c_sub(input cplx_t a, input cplx_t b);
        cplx_t r;
        r.re = a.re - b.re;
        r.im = a.im - b.im;
        return r;
    endfunction

    // Forward multiplies by -j, inverse by +j.
    function automatic cplx_t c_rot(input cplx_t a, input mode_t m);
        cplx_t r;
        if (m == FWD) begin
            r.re = a.im;
            r.im = -a.re;
        end else begin
            r.re = -a.im;
            r.im = a.re;
        end
        return r;
    endfunction

    // Shift code 3 is clamped to SHIFT_MAX.
    function automatic sat_res_t sat_rnd(input wide_t v, input logic [1:0] s, input int w_out);
        sat_res_t res;
        int       sh;
        wide_t    rnd;
        wide_t    t;
        wide_t    hi;
        wide_t    lo;
        sh  = (int'(s) > SHIFT_MAX) ? SHIFT_MAX : int'(s);
        rnd = (sh > 0) ? (wide_t'(1) <<< (sh - 1)) : '0;
        t   = (v + rnd) >>> sh;
        hi  = (wide_t'(1) <<< (w_out - 1)) - wide_t'(1);
        lo  = ~hi;
        res.ovf = 1'b0;
        res.v   = t;
        if (t > hi) begin
            res.v   = hi;
            res.ovf = 1'b1;
        end else if (t < lo) begin
            res.v   = lo;
            res.ovf = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mrd_dft_rdx4_cfg_scale_sat.sv
// Per-component output scaling: round-half-up right shift, then saturate to WO
// bits, flagging when the clamp engaged.
module mrd_scale_sat
    import mrd_dft_pkg::*;
#(
    parameter int WI = 32,
    parameter int WO = 30
) (
    input  logic signed [WI-1:0] din,
    input  logic        [1:0]    shift,
    output logic signed [WO-1:0] dout,
    output logic                 ovf
);

    sat_res_t res;
    logic     unused_hi;

    always_comb begin
        res       = sat_rnd(wide_t'(din), shift, WO);
        dout      = res.v[WO-1:0];
        ovf       = res.ovf;
        unused_hi = ^res.v[W_MAX-1:WO];
    end

endmodule

// File: rtl/mrd_dft_rdx4_cfg.sv
// Radix-4 / dual radix-2 DFT butterfly with per-sample direction and scaling,
// saturation with sticky overflow, and a 3-stage globally stalled pipeline.
module mrd_dft_rdx4_cfg
    import mrd_dft_pkg::*;
#(
    parameter int wDataIn  = 30,
    parameter int wDataOut = 30
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_val,
    output logic                       in_rdy,
    input  logic                       in_inv,
    input  logic                       in_rdx2,
    input  logic        [1:0]          in_shift,
    input  logic signed [wDataIn-1:0]  din_real [0:4],
    input  logic signed [wDataIn-1:0]  din_imag [0:4],
    output logic                       out_val,
    input  logic                       out_rdy,
    output logic signed [wDataOut-1:0] dout_real [0:4],
    output logic signed [wDataOut-1:0] dout_imag [0:4],
    output logic                       ovf_sticky,
    input  logic                       ovf_clr
);

    localparam int WI = wDataIn + 2;

    logic                       en;
    logic                       v1, v2, v3;
    mode_t                      mode1;
    logic                       rdx1;
    logic [1:0]                 sh1, sh2;
    logic signed [WI-1:0]       a_re [4];
    logic signed [WI-1:0]       a_im [4];
    logic signed [WI-1:0]       x_re [4];
    logic signed [WI-1:0]       x_im [4];
    logic signed [wDataOut-1:0] y_re [4];
    logic signed [wDataOut-1:0] y_im [4];
    logic signed [wDataOut-1:0] q_re [4];
    logic signed [wDataOut-1:0] q_im [4];
    logic [3:0]                 ovf_re, ovf_im;
    cplx_t                      xin [4];
    cplx_t                      a_nxt [4];
    cplx_t                      a_cur [4];
    cplx_t                      x_nxt [4];
    cplx_t                      rot3;
    logic                       unused_bits;

    // Valid/ready: a sample moves on a cycle where valid && ready; the whole
    // pipeline advances together whenever the output register is free.
    assign en      = !v3 || out_rdy;
    assign in_rdy  = en;
    assign out_val = v3;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            xin[k].re   = wide_t'(din_real[k]);
            xin[k].im   = wide_t'(din_imag[k]);
            a_cur[k].re = wide_t'(a_re[k]);
            a_cur[k].im = wide_t'(a_im[k]);
        end
    end

    always_comb begin
        if (in_rdx2) begin
            a_nxt[0] = c_add(xin[0], xin[1]);
            a_nxt[1] = c_sub(xin[0], xin[1]);
            a_nxt[2] = c_add(xin[2], xin[3]);
            a_nxt[3] = c_sub(xin[2], xin[3]);
        end else begin
            a_nxt[0] = c_add(xin[0], xin[2]);
            a_nxt[2] = c_sub(xin[0], xin[2]);
            a_nxt[1] = c_add(xin[1], xin[3]);
            a_nxt[3] = c_sub(xin[1], xin[3]);
        end
    end

    always_comb begin
        rot3 = c_rot(a_cur[3], mode1);
        if (rdx1) begin
            for (int k = 0; k < 4; k++) x_nxt[k] = a_cur[k];
        end else begin
            x_nxt[0] = c_add(a_cur[0], a_cur[1]);
            x_nxt[2] = c_sub(a_cur[0], a_cur[1]);
            x_nxt[1] = c_add(a_cur[2], rot3);
            x_nxt[3] = c_sub(a_cur[2], rot3);
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        mrd_scale_sat #(.WI(WI), .WO(wDataOut)) u_re (
            .din(x_re[k]), .shift(sh2), .dout(y_re[k]), .ovf(ovf_re[k])
        );
        mrd_scale_sat #(.WI(WI), .WO(wDataOut)) u_im (
            .din(x_im[k]), .shift(sh2), .dout(y_im[k]), .ovf(ovf_im[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            mode1 <= FWD;
            rdx1  <= 1'b0;
            sh1   <= '0;
            sh2   <= '0;
            for (int k = 0; k < 4; k++) begin
                a_re[k] <= '0;
                a_im[k] <= '0;
                x_re[k] <= '0;
                x_im[k] <= '0;
                q_re[k] <= '0;
                q_im[k] <= '0;
            end
        end else if (en) begin
            v1    <= in_val;
            v2    <= v1;
            v3    <= v2;
            mode1 <= mode_t'(in_inv);
            rdx1  <= in_rdx2;
            sh1   <= in_shift;
            sh2   <= sh1;
            for (int k = 0; k < 4; k++) begin
                a_re[k] <= a_nxt[k].re[WI-1:0];
                a_im[k] <= a_nxt[k].im[WI-1:0];
                x_re[k] <= x_nxt[k].re[WI-1:0];
                x_im[k] <= x_nxt[k].im[WI-1:0];
                q_re[k] <= y_re[k];
                q_im[k] <= y_im[k];
            end
        end
    end

    // Set takes priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_sticky <= 1'b0;
        else if (en && v2 && (|{ovf_re, ovf_im})) ovf_sticky <= 1'b1;
        else if (ovf_clr) ovf_sticky <= 1'b0;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            dout_real[k] = q_re[k];
            dout_imag[k] = q_im[k];
        end
        dout_real[4] = '0;
        dout_imag[4] = '0;
    end

    // Lane 4 inputs and the sign-extension headroom of the wide sums are dropped.
    always_comb begin
        unused_bits = ^{din_real[4], din_imag[4]};
        for (int k = 0; k < 4; k++) begin
            unused_bits = unused_bits ^ (^a_nxt[k].re[W_MAX-1:WI]) ^ (^a_nxt[k].im[W_MAX-1:WI])
                        ^ (^x_nxt[k].re[W_MAX-1:WI]) ^ (^x_nxt[k].im[W_MAX-1:WI]);
        end
    end

endmodule

// File: tb/tb_mrd_dft_rdx4_cfg.sv
// Bench for mrd_dft_rdx4_cfg: directed vector table, random backpressured
// stream against a direct-DFT reference model, and mid-stream reset.
module tb_mrd_dft_rdx4_cfg;

  localparam int W_IN  = 16;
  localparam int W_OUT = 16;
  localparam int W     = 8 * W_OUT;
  localparam int N_RAND = 150;

  logic clk = 1'b0;
  logic rst_n;
  logic in_val, in_rdy, in_inv, in_rdx2;
  logic [1:0] in_shift;
  logic signed [W_IN-1:0] din_real [0:4];
  logic signed [W_IN-1:0] din_imag [0:4];
  logic out_val, out_rdy;
  logic signed [W_OUT-1:0] dout_real [0:4];
  logic signed [W_OUT-1:0] dout_imag [0:4];
  logic ovf_sticky, ovf_clr;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int xr[4];
    bit inv;
    bit rdx2;
    int sh;
    int er[4];
    int ei[4];
    bit eovf;
  } vec_t;
  vec_t vec_q[$];

  logic [W-1:0] exp_q[$];

  mrd_dft_rdx4_cfg #(.wDataIn(W_IN), .wDataOut(W_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_val(in_val), .in_rdy(in_rdy), .in_inv(in_inv), .in_rdx2(in_rdx2),
    .in_shift(in_shift), .din_real(din_real), .din_imag(din_imag),
    .out_val(out_val), .out_rdy(out_rdy),
    .dout_real(dout_real), .dout_imag(dout_imag),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] get_dout();
    logic [W-1:0] r;
    for (int k = 0; k < 4; k++) begin
      r[2*k*W_OUT +: W_OUT]     = dout_real[k];
      r[(2*k+1)*W_OUT +: W_OUT] = dout_imag[k];
    end
    return r;
  endfunction

  // Reference: direct 4-point DFT (or two 2-point DFTs), then scale and clamp.
  function automatic void model(input longint xr[4], input longint xi[4], input bit inv,
                                input bit rdx2, input int sh,
                                output logic [W-1:0] res, output bit ovf);
    longint yr[4], yi[4];
    longint v, hi, lo;
    int s, p, e;
    if (rdx2) begin
      for (int b = 0; b < 4; b += 2) begin
        yr[b]   = xr[b] + xr[b+1];  yi[b]   = xi[b] + xi[b+1];
        yr[b+1] = xr[b] - xr[b+1];  yi[b+1] = xi[b] - xi[b+1];
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        yr[k] = 0;
        yi[k] = 0;
        for (int n = 0; n < 4; n++) begin
          p = (n * k) % 4;
          e = inv ? p : (4 - p) % 4;   // power of +j
          case (e)
            0: begin yr[k] += xr[n]; yi[k] += xi[n]; end
            1: begin yr[k] -= xi[n]; yi[k] += xr[n]; end
            2: begin yr[k] -= xr[n]; yi[k] -= xi[n]; end
            default: begin yr[k] += xi[n]; yi[k] -= xr[n]; end
          endcase
        end
      end
    end
    s   = (sh > 2) ? 2 : sh;
    hi  = (longint'(1) <<< (W_OUT - 1)) - 1;
    lo  = -hi - 1;
    ovf = 1'b0;
    res = '0;
    for (int c = 0; c < 8; c++) begin
      v = c[0] ? yi[c/2] : yr[c/2];
      if (s > 0) v = v + (longint'(1) <<< (s - 1));
      v = v >>> s;
      if (v > hi) begin v = hi; ovf = 1'b1; end
      if (v < lo) begin v = lo; ovf = 1'b1; end
      res[c*W_OUT +: W_OUT] = v[W_OUT-1:0];
    end
  endfunction

  // ---------------- driver helpers ----------------
  task automatic add_vec(input int a0, input int a1, input int a2, input int a3,
                         input bit inv, input bit rdx2, input int sh,
                         input int r0, input int r1, input int r2, input int r3,
                         input int i0, input int i1, input int i2, input int i3, input bit eovf);
    vec_t v;
    v.xr[0] = a0; v.xr[1] = a1; v.xr[2] = a2; v.xr[3] = a3;
    v.inv = inv; v.rdx2 = rdx2; v.sh = sh;
    v.er[0] = r0; v.er[1] = r1; v.er[2] = r2; v.er[3] = r3;
    v.ei[0] = i0; v.ei[1] = i1; v.ei[2] = i2; v.ei[3] = i3;
    v.eovf = eovf;
    vec_q.push_back(v);
  endtask

  function automatic logic signed [W_IN-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return {1'b0, {(W_IN-1){1'b1}}};
      1: return {1'b1, {(W_IN-1){1'b0}}};
      default: return W_IN'($urandom);
    endcase
  endfunction

  task automatic clear_inputs();
    in_val = 1'b0; in_inv = 1'b0; in_rdx2 = 1'b0; in_shift = 2'd0;
    for (int k = 0; k < 5; k++) begin
      din_real[k] = '0;
      din_imag[k] = '0;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    longint xr[4], xi[4];
    logic [W-1:0] exp_v, held;
    bit m_ovf, exp_ovf, hold, seen;
    int sent;

    add_vec(1, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1,  0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 0, 0, 0, 0,  1, 0, -1, 0,  0, -1, 0, 1, 0);
    add_vec(0, 1, 0, 0, 1, 0, 0,  1, 0, -1, 0,  0, 1, 0, -1, 0);
    add_vec(3, 1, 5, 2, 0, 1, 0,  4, 2, 7, 3,  0, 0, 0, 0, 0);
    add_vec(3, 1, 5, 2, 1, 1, 0,  4, 2, 7, 3,  0, 0, 0, 0, 0);
    add_vec(1, 1, 0, 0, 0, 0, 1,  1, 1, 0, 1,  0, 0, 0, 1, 0);
    add_vec(4, 4, 4, 4, 0, 0, 2,  4, 0, 0, 0,  0, 0, 0, 0, 0);
    add_vec(32767, 32767, 32767, 32767, 0, 0, 0,  32767, 0, 0, 0,  0, 0, 0, 0, 1);
    add_vec(4, 4, 4, 4, 0, 0, 3,  4, 0, 0, 0,  0, 0, 0, 0, 0);
    add_vec(-3, 0, 0, 0, 0, 0, 1,  -1, -1, -1, -1,  0, 0, 0, 0, 0);
    add_vec(-32768, -32768, -32768, -32768, 1, 0, 0,  -32768, 0, 0, 0,  0, 0, 0, 0, 1);

    rst_n = 1'b0; out_rdy = 1'b1; ovf_clr = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_val", longint'(out_val), 0);
    check("rst_in_rdy", longint'(in_rdy), 1);
    check("rst_ovf", longint'(ovf_sticky), 0);
    check_vec("rst_dout", get_dout(), '0);
    rst_n = 1'b1;
    step();

    // Directed table: one sample at a time, exact latency checked.
    for (int i = 0; i < vec_q.size(); i++) begin
      v = vec_q[i];
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check($sformatf("v%0d_ovf_clr", i), longint'(ovf_sticky), 0);
      in_val = 1'b1; in_inv = v.inv; in_rdx2 = v.rdx2; in_shift = 2'(v.sh);
      for (int k = 0; k < 4; k++) din_real[k] = W_IN'(v.xr[k]);
      din_real[4] = 16'sh1234;
      din_imag[4] = -16'sh0777;
      check($sformatf("v%0d_in_rdy", i), longint'(in_rdy), 1);
      step();
      clear_inputs();
      check($sformatf("v%0d_lat1", i), longint'(out_val), 0);
      step();
      check($sformatf("v%0d_lat2", i), longint'(out_val), 0);
      step();
      check($sformatf("v%0d_lat3", i), longint'(out_val), 1);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("v%0d_re%0d", i, k), longint'(dout_real[k]), v.er[k]);
        check($sformatf("v%0d_im%0d", i, k), longint'(dout_imag[k]), v.ei[k]);
      end
      check($sformatf("v%0d_lane4", i), longint'(dout_real[4]) | longint'(dout_imag[4]), 0);
      check($sformatf("v%0d_ovf", i), longint'(ovf_sticky), longint'(v.eovf));
    end

    // Random stream with random backpressure.
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    exp_ovf = 1'b0; hold = 1'b0; sent = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (sent == N_RAND && exp_q.size() == 0) break;
      if (hold) begin
        check("stall_val", longint'(out_val), 1);
        check_vec("stall_dout", get_dout(), held);
      end
      out_rdy = ($urandom_range(0, 2) != 0);
      in_val  = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
      in_inv = 1'($urandom_range(0, 1));
      in_rdx2 = 1'($urandom_range(0, 1));
      in_shift = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) begin
        din_real[k] = rnd_val();
        din_imag[k] = rnd_val();
        xr[k] = longint'(din_real[k]);
        xi[k] = longint'(din_imag[k]);
      end
      #1;
      if (out_val && out_rdy) begin
        if (exp_q.size() == 0) check("stream_unexpected", 1, 0);
        else check_vec("stream", get_dout(), exp_q.pop_front());
      end
      if (in_val && in_rdy) begin
        model(xr, xi, in_inv, in_rdx2, int'(in_shift), exp_v, m_ovf);
        exp_q.push_back(exp_v);
        exp_ovf = exp_ovf | m_ovf;
        sent++;
      end
      hold = out_val && !out_rdy;
      held = get_dout();
      step();
    end
    clear_inputs();
    out_rdy = 1'b1;
    check("stream_drained", longint'(exp_q.size()), 0);
    check("stream_sent", longint'(sent), N_RAND);
    check("stream_ovf", longint'(ovf_sticky), longint'(exp_ovf));

    // Reset while the pipeline is full and stalled.
    out_rdy = 1'b0;
    for (int n = 0; n < 3; n++) begin
      in_val = 1'b1;
      din_real[0] = rnd_val();
      step();
    end
    clear_inputs();
    step();
    check("pre_rst_val", longint'(out_val), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_val", longint'(out_val), 0);
    check("async_rst_rdy", longint'(in_rdy), 1);
    check("async_rst_ovf", longint'(ovf_sticky), 0);
    check_vec("async_rst_dout", get_dout(), '0);
    step();
    rst_n = 1'b1;
    out_rdy = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      seen = seen | out_val;
      step();
    end
    check("no_stale_out", longint'(seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mrd_dft_rdx4_cfg.md
Name: mrd_dft_rdx4_cfg

Overview:
Parametrised radix-4 DFT butterfly for the mixed-radix DFT datapath. It adds several features: forward/inverse mode per sample, dual radix-2 mode, per-sample output scaling with round-half-up and saturation, a sticky overflow flag, and valid/ready backpressure. The five-lane data ports match the other mixed-radix engines; lane 4 always outputs zero. Pipeline depth is 3 stages.

Parameters:
wDataIn, 30, signed input width per real/imag component
wDataOut, 30, signed output width per component; must be greater than or equal to wDataIn-2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_val  in  1  input sample valid
in_rdy  out  1  block accepts the input sample this cycle
in_inv  in  1  0 = forward DFT (W=e^-j), 1 = inverse DFT (conjugate twiddles)
in_rdx2  in  1  1 = two independent radix-2 butterflies
in_shift  in  2  right-shift applied at the output, legal range 0..2
din_real  in  [0:4]x wDataIn  real inputs; lane 4 ignored
din_imag  in  [0:4]x wDataIn  imag inputs; lane 4 ignored
out_val  out  1  output sample valid
out_rdy  in  1  downstream accepts the output sample
dout_real  out  [0:4]x wDataOut  real results; lane 4 = 0
dout_imag  out  [0:4]x wDataOut  imag results; lane 4 = 0
ovf_sticky  out  1  set when any component saturates
ovf_clr  in  1  synchronous clear for ovf_sticky

Behaviour:
- Reset is asynchronous, active-low, and clears every register. All outputs are 0 during reset, including out_val and ovf_sticky. in_rdy=1 after reset.
- Reset asserted mid-operation drops all in-flight samples. No partial output is emitted.
- Global enable: en = !out_val || out_rdy. in_rdy = en.
- When en=0, every stage register and every valid bit holds. When en=1, all stages advance together. Bubbles are not compressed.
- An input is accepted when in_val && in_rdy. Its result appears at out_val exactly 3 enabled cycles later.
- dout and out_val stay stable while out_val && !out_rdy.
- in_inv, in_rdx2 and in_shift are pipelined alongside the data. They take effect per sample; mode changes on consecutive samples are legal.
- Internal width is wI = wDataIn+2. Inputs are sign-extended. There is no wrap anywhere inside the pipeline.
- Stage 1, radix-4:
  - a0 = x0+x2, a2 = x0-x2
  - a1 = x1+x3, a3 = x1-x3
- Stage 1, radix-2 mode:
  - a0 = x0+x1, a1 = x0-x1
  - a2 = x2+x3, a3 = x2-x3
- Stage 2, radix-4 forward:
  - X0 = a0+a1, X2 = a0-a1
  - X1 = (a2.re+a3.im, a2.im-a3.re)
  - X3 = (a2.re-a3.im, a2.im+a3.re)
- Stage 2, radix-4 inverse: X1 and X3 formulas are swapped (the ±j sign flips).
- Stage 2, radix-2 mode: X_k = a_k. in_inv has no effect.
- Stage 3, scale and saturate, per component:
  - s=in_shift; v' = (v + (s>0 ? 1<<(s-1) : 0)) >>> s, arithmetic shift.
  - Then saturate to the [-2^(wDataOut-1), 2^(wDataOut-1)-1] range.
- ovf_sticky is set in the cycle after any valid stage-3 component saturates.
- ovf_clr clears ovf_sticky. If a set and ovf_clr occur in the same cycle, set wins.
- in_shift=3 is illegal. It is treated as 2.

Decomposition:
- Package mrd_dft_pkg holds:
  - typedef cplx_t for an internal-width complex value
  - mode enum {FWD, INV}
  - constant SHIFT_MAX=2
  - function sat_rnd(v, s) performing the round and saturate
- One sub-module is natural: mrd_scale_sat. It performs the per-component round/shift/saturate and reports an overflow bit. The top module instantiates 8 of them.

Test Plan:
- Impulse: x=[1,0,0,0], fwd, shift 0 → out=[1,1,1,1] (imag 0), latency 3, lane4=0.
- Single tone: x=[0,1,0,0], fwd → X=[1,-j,-1,+j]. The same input with inv=1 → X=[1,+j,-1,-j].
- Dual radix-2: x=[3,1,5,2], rdx2=1 → out=[4,2,7,3]. Repeat with inv=1 → same result.
- Round and shift:
  - x=[1,1,0,0], fwd, shift 1 → X0=1, X1=(1,0), X2=0, X3=(1,1).
  - x=[4,4,4,4], shift 2 → X0=4.
- Saturation, wDataIn=wDataOut=16: all real inputs = 32767, shift 0 → X0.re=32767, ovf_sticky=1. ovf_clr pulse → ovf_sticky=0.
- Backpressure and reset:
  - Stream 10 samples with out_rdy toggling randomly → order preserved, no loss or duplication, dout stable while stalled.
  - Assert rst_n low mid-stream → out_val=0 immediately (asynchronous); no stale outputs after release.
